// File: rtl/fft_pkg.sv
// Shared FFT definitions: default geometry, read-FSM encoding and a bit-reversal helper
// used by the input reorder stage, the FFT core and the output reorder stage.
package fft_pkg;

    localparam int FFT_WIDTH     = 8;
    localparam int FFT_POINTS    = 64;
    localparam int FFT_LOGPOINTS = 6;

    // Widest index handled by bitrev; covers frames up to 1024 points.
    localparam int REV_MAXBITS = 10;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // Reverses the low nbits of v; bits at and above nbits come back as zero.
    function automatic logic [REV_MAXBITS-1:0] bitrev(input logic [REV_MAXBITS-1:0] v,
                                                      input int nbits);
        logic [REV_MAXBITS-1:0] r;
        logic [3:0]             idx;
        r = '0;
        for (int i = 0; i < REV_MAXBITS; i++) begin
            idx = 4'(nbits - 1 - i);
            if (i < nbits) r[i] = v[idx];
        end
        return r;
    endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: port A writes, port B reads synchronously with a read enable.
// The read data register holds its value whenever the read enable is low.
module dpram #(
    parameter int DW = 16,
    parameter int AW = 5
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_input_bank.sv
// One ping-pong frame buffer: the lower dpram holds samples n < N/2, the upper holds
// n >= N/2, both at address n mod N/2, so one read address yields a full butterfly pair.
module fft_input_bank
    import fft_pkg::*;
#(
    parameter int width     = FFT_WIDTH,
    parameter int logpoints = FFT_LOGPOINTS
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic                   i_upper,
    input  logic [logpoints-2:0]   i_waddr,
    input  logic [2*width-1:0]     i_wdata,
    input  logic                   i_re,
    input  logic [logpoints-2:0]   i_raddr,
    output logic [2*width-1:0]     o_lo,
    output logic [2*width-1:0]     o_hi
);

    logic w_we_lo;
    logic w_we_hi;

    assign w_we_lo = i_we && !i_upper;
    assign w_we_hi = i_we &&  i_upper;

    dpram #(.DW(2*width), .AW(logpoints-1)) u_lo (
        .i_clk   (i_clk),
        .i_we    (w_we_lo),
        .i_waddr (i_waddr),
        .i_wdata (i_wdata),
        .i_re    (i_re),
        .i_raddr (i_raddr),
        .o_rdata (o_lo)
    );

    dpram #(.DW(2*width), .AW(logpoints-1)) u_hi (
        .i_clk   (i_clk),
        .i_we    (w_we_hi),
        .i_waddr (i_waddr),
        .i_wdata (i_wdata),
        .i_re    (i_re),
        .i_raddr (i_raddr),
        .o_rdata (o_hi)
    );

endmodule

// File: rtl/fft_input_reorder.sv
// Natural-order sample input, ping-pong frame buffering, and bit-reversed pair output
// (two samples per cycle) towards the radix-2 FFT butterfly pipeline.
module fft_input_reorder
    import fft_pkg::*;
#(
    parameter int width     = FFT_WIDTH,
    parameter int points    = FFT_POINTS,
    parameter int logpoints = FFT_LOGPOINTS
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ce,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [width-1:0] dr,
    input  logic [width-1:0] di,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             sof_o,
    output logic [width-1:0] ar,
    output logic [width-1:0] ai,
    output logic [width-1:0] br,
    output logic [width-1:0] bi
);

    localparam int HA = logpoints - 1;

    logic [1:0]           r_full;
    logic                 r_wr_sel;
    logic [logpoints-1:0] r_wcnt;
    logic                 r_rd_sel;
    logic [HA-1:0]        r_rcnt;
    logic [0:0]           r_state;

    logic [HA-1:0]        r_raddr;
    logic                 r_issue;
    logic                 r_first;
    logic                 r_last;
    logic                 r_sel;

    logic                 r_valid;
    logic                 r_sof;
    logic                 r_osel;

    logic                 w_accept;
    logic                 w_adv;
    logic                 w_issue;
    logic [1:0]           w_set;
    logic [1:0]           w_clr;
    logic [2*width-1:0]   w_wdata;
    logic [2*width-1:0]   w_lo0;
    logic [2*width-1:0]   w_hi0;
    logic [2*width-1:0]   w_lo1;
    logic [2*width-1:0]   w_hi1;
    logic [2*width-1:0]   w_a;
    logic [2*width-1:0]   w_b;

    assign ready_o  = !r_full[r_wr_sel];
    assign w_accept = ce && valid_i && ready_o;
    assign w_adv    = ce && (!r_valid || ready_i);
    assign w_issue  = (r_state == ST_DRAIN) && w_adv;
    assign w_wdata  = {dr, di};

    // A buffer is released only once its final pair has actually been read out of the RAM,
    // so a long stall cannot let the writer overwrite a location still waiting to be read.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_accept && (r_wcnt == '1)) w_set[r_wr_sel] = 1'b1;
        if (w_adv && r_issue && r_last) w_clr[r_sel] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_full   <= '0;
            r_wr_sel <= 1'b0;
            r_wcnt   <= '0;
        end else begin
            r_full <= (r_full | w_set) & ~w_clr;
            if (w_accept) begin
                r_wcnt <= r_wcnt + 1'b1;
                if (r_wcnt == '1) r_wr_sel <= ~r_wr_sel;
            end
        end
    end

    // Address stage: walks rcnt through the frame and registers the bit-reversed address.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= ST_IDLE;
            r_rd_sel <= 1'b0;
            r_rcnt   <= '0;
            r_raddr  <= '0;
            r_issue  <= 1'b0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
            r_sel    <= 1'b0;
        end else if (ce) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_full[r_rd_sel]) begin
                        r_state <= ST_DRAIN;
                        r_rcnt  <= '0;
                    end
                end
                default: begin
                    if (w_adv) begin
                        r_rcnt <= r_rcnt + 1'b1;
                        if (r_rcnt == '1) begin
                            r_rd_sel <= ~r_rd_sel;
                            if (!r_full[~r_rd_sel]) r_state <= ST_IDLE;
                        end
                    end
                end
            endcase
            if (w_adv) begin
                r_issue <= w_issue;
                r_first <= w_issue && (r_rcnt == '0);
                r_last  <= w_issue && (r_rcnt == '1);
                r_sel   <= r_rd_sel;
                r_raddr <= HA'(bitrev(REV_MAXBITS'(r_rcnt), HA));
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_osel  <= 1'b0;
        end else if (w_adv) begin
            r_valid <= r_issue;
            r_sof   <= r_first;
            r_osel  <= r_sel;
        end
    end

    fft_input_bank #(.width(width), .logpoints(logpoints)) u_bank0 (
        .i_clk   (CLK),
        .i_we    (w_accept && !r_wr_sel),
        .i_upper (r_wcnt[logpoints-1]),
        .i_waddr (r_wcnt[logpoints-2:0]),
        .i_wdata (w_wdata),
        .i_re    (w_adv),
        .i_raddr (r_raddr),
        .o_lo    (w_lo0),
        .o_hi    (w_hi0)
    );

    fft_input_bank #(.width(width), .logpoints(logpoints)) u_bank1 (
        .i_clk   (CLK),
        .i_we    (w_accept && r_wr_sel),
        .i_upper (r_wcnt[logpoints-1]),
        .i_waddr (r_wcnt[logpoints-2:0]),
        .i_wdata (w_wdata),
        .i_re    (w_adv),
        .i_raddr (r_raddr),
        .o_lo    (w_lo1),
        .o_hi    (w_hi1)
    );

    assign w_a     = r_osel ? w_lo1 : w_lo0;
    assign w_b     = r_osel ? w_hi1 : w_hi0;
    assign valid_o = r_valid;
    assign sof_o   = r_sof;
    assign ar      = r_valid ? w_a[2*width-1:width] : '0;
    assign ai      = r_valid ? w_a[width-1:0]       : '0;
    assign br      = r_valid ? w_b[2*width-1:width] : '0;
    assign bi      = r_valid ? w_b[width-1:0]       : '0;

endmodule

// File: tb/tb_fft_input_reorder.sv
// Scoreboard bench for fft_input_reorder: frames are modelled as they are accepted and the
// expected bit-reversed pairs are queued, then popped as the DUT hands each pair over.
module tb_fft_input_reorder;

    typedef struct packed {
        logic       sof;
        logic [7:0] ar;
        logic [7:0] ai;
        logic [7:0] br;
        logic [7:0] bi;
    } pair_t;

    logic       CLK;
    logic       RST;
    logic       ce;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] dr;
    logic [7:0] di;
    logic       valid_o;
    logic       ready_i;
    logic       sof_o;
    logic [7:0] ar;
    logic [7:0] ai;
    logic [7:0] br;
    logic [7:0] bi;

    pair_t      sbq [$];
    logic [15:0] mfr [0:63];
    int         mcnt;
    int         checks;
    int         errors;
    int         stalls;
    bit         randReady;

    fft_input_reorder #(.width(8), .points(64), .logpoints(6)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .ce      (ce),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .dr      (dr),
        .di      (di),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .sof_o   (sof_o),
        .ar      (ar),
        .ai      (ai),
        .br      (br),
        .bi      (bi)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int rev6(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 6; i++)
            if ((v & (1 << i)) != 0) r = r | (1 << (5 - i));
        return r;
    endfunction

    // Model and scoreboard, sampled on the falling edge ahead of the edge that acts.
    always @(negedge CLK) begin
        if (!RST) begin
            mcnt = 0;
        end else begin
            if (ce && valid_i && ready_o) begin
                mfr[mcnt] = {dr, di};
                mcnt = mcnt + 1;
                if (mcnt == 64) begin
                    for (int k = 0; k < 32; k++) begin
                        pair_t e;
                        int    ia;
                        int    ib;
                        ia    = rev6(2 * k);
                        ib    = rev6(2 * k + 1);
                        e.sof = (k == 0);
                        e.ar  = mfr[ia][15:8];
                        e.ai  = mfr[ia][7:0];
                        e.br  = mfr[ib][15:8];
                        e.bi  = mfr[ib][7:0];
                        sbq.push_back(e);
                    end
                    mcnt = 0;
                end
            end
            if (ce && valid_o && ready_i) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL pair_unexpected: got sof=%b a=(%0d,%0d) b=(%0d,%0d), required no pair",
                             sof_o, ar, ai, br, bi);
                end else begin
                    pair_t e;
                    e = sbq.pop_front();
                    if ({sof_o, ar, ai, br, bi} !== e) begin
                        errors++;
                        $display("[TB] FAIL pair_data: got sof=%b a=(%0d,%0d) b=(%0d,%0d), required sof=%b a=(%0d,%0d) b=(%0d,%0d)",
                                 sof_o, ar, ai, br, bi, e.sof, e.ar, e.ai, e.br, e.bi);
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_sample(input logic [7:0] r, input logic [7:0] i);
        int guard;
        bit done;
        guard   = 0;
        done    = 0;
        dr      = r;
        di      = i;
        valid_i = 1'b1;
        while (!done) begin
            if (randReady) ready_i = 1'($urandom_range(0, 1));
            @(negedge CLK);
            done = (ready_o === 1'b1) && ce;
            if (!done) stalls++;
            @(posedge CLK);
            #1;
            guard++;
            if (!done && guard > 3000) begin
                checks++;
                errors++;
                $display("[TB] FAIL send_timeout: ready_o=%b after %0d cycles, required 1", ready_o, guard);
                done = 1;
            end
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((sbq.size() != 0 || valid_o === 1'b1) && g < 2000) begin
            @(posedge CLK);
            #1;
            g++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; ce = 1'b1; valid_i = 1'b0; ready_i = 1'b1; dr = '0; di = '0;
        randReady = 0;
        #23;
        checks += 5;
        if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b required 1", ready_o); end
        if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b required 0", valid_o); end
        if (sof_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_sof: got %b required 0", sof_o); end
        if ({ar, ai} !== 16'h0) begin errors++; $display("[TB] FAIL reset_a: got %h required 0", {ar, ai}); end
        if ({br, bi} !== 16'h0) begin errors++; $display("[TB] FAIL reset_b: got %h required 0", {br, bi}); end
        RST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_ramp();
        int lat;
        for (int n = 0; n < 64; n++) send_sample(8'(n), 8'(-n));
        valid_i = 1'b0;
        lat = 0;
        while (valid_o !== 1'b1 && lat < 10) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        checks += 6;
        if (lat != 3) begin errors++; $display("[TB] FAIL ramp_latency: got %0d cycles required 3", lat); end
        if (sof_o !== 1'b1) begin errors++; $display("[TB] FAIL ramp_sof: got %b required 1", sof_o); end
        if (ar !== 8'd0 || ai !== 8'd0) begin errors++; $display("[TB] FAIL ramp_a0: got (%0d,%0d) required (0,0)", ar, ai); end
        if (br !== 8'd32) begin errors++; $display("[TB] FAIL ramp_br0: got %0d required 32", br); end
        if (bi !== 8'hE0) begin errors++; $display("[TB] FAIL ramp_bi0: got %h required e0", bi); end
        wait_drain();
        if (sbq.size() != 0) begin errors++; $display("[TB] FAIL ramp_drain: got %0d pending required 0", sbq.size()); end
    endtask

    task automatic test_continuous();
        stalls = 0;
        for (int n = 0; n < 256; n++) send_sample(8'($urandom), 8'($urandom));
        valid_i = 1'b0;
        wait_drain();
        checks += 2;
        if (stalls != 0) begin errors++; $display("[TB] FAIL cont_ready: got %0d stall cycles required 0", stalls); end
        if (sbq.size() != 0) begin errors++; $display("[TB] FAIL cont_drain: got %0d pending required 0", sbq.size()); end
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        for (int n = 0; n < 128; n++) send_sample(8'(n + 7), 8'(3 * n));
        valid_i = 1'b0;
        repeat (10) begin @(posedge CLK); #1; end
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            checks += 3;
            if (ready_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready: got %b required 0", ready_o); end
            if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid: got %b required 1", valid_o); end
            if (sbq.size() == 0 || {sof_o, ar, ai, br, bi} !== sbq[0] || sof_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bp_hold: got sof=%b a=(%0d,%0d) b=(%0d,%0d), required frame head pair", sof_o, ar, ai, br, bi);
            end
        end
        @(posedge CLK);
        #1;
        ready_i = 1'b1;
        wait_drain();
        checks += 2;
        if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready: got %b required 1", ready_o); end
        if (sbq.size() != 0) begin errors++; $display("[TB] FAIL bp_drain: got %0d pending required 0", sbq.size()); end
    endtask

    task automatic test_random();
        randReady = 1;
        for (int n = 0; n < 8 * 64; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                valid_i = 1'b0;
                dr = 8'($urandom);
                repeat ($urandom_range(1, 3)) begin
                    ready_i = 1'($urandom_range(0, 1));
                    @(posedge CLK);
                    #1;
                end
            end
            send_sample(8'($urandom), 8'($urandom));
        end
        valid_i   = 1'b0;
        randReady = 0;
        ready_i   = 1'b1;
        wait_drain();
        checks++;
        if (sbq.size() != 0) begin errors++; $display("[TB] FAIL rand_drain: got %0d pending required 0", sbq.size()); end
    endtask

    task automatic test_ce();
        int g;
        for (int n = 0; n < 30; n++) send_sample(8'(n), 8'(-n));
        ce = 1'b0;
        dr = 8'(30); di = 8'(-30); valid_i = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            checks += 2;
            if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL ce_fill_ready: got %b required 1", ready_o); end
            if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ce_fill_valid: got %b required 0", valid_o); end
            @(posedge CLK);
            #1;
        end
        ce = 1'b1;
        for (int n = 30; n < 64; n++) send_sample(8'(n), 8'(-n));
        valid_i = 1'b0;
        g = 0;
        while (valid_o !== 1'b1 && g < 20) begin @(posedge CLK); #1; g++; end
        repeat (3) begin @(posedge CLK); #1; end
        ce = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            checks += 2;
            if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL ce_drain_valid: got %b required 1", valid_o); end
            if (sbq.size() == 0 || {sof_o, ar, ai, br, bi} !== sbq[0]) begin
                errors++;
                $display("[TB] FAIL ce_drain_hold: got a=(%0d,%0d) b=(%0d,%0d), required next queued pair", ar, ai, br, bi);
            end
            @(posedge CLK);
            #1;
        end
        ce = 1'b1;
        wait_drain();
        checks++;
        if (sbq.size() != 0) begin errors++; $display("[TB] FAIL ce_drain: got %0d pending required 0", sbq.size()); end
    endtask

    task automatic test_reset_midframe();
        for (int n = 0; n < 40; n++) send_sample(8'($urandom), 8'($urandom));
        valid_i = 1'b0;
        RST     = 1'b0;
        #1;
        checks += 3;
        if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid: got %b required 0", valid_o); end
        if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_ready: got %b required 1", ready_o); end
        if ({sof_o, ar, ai, br, bi} !== 33'h0) begin errors++; $display("[TB] FAIL rst_mid_out: got %h required 0", {sof_o, ar, ai, br, bi}); end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        for (int n = 0; n < 64; n++) send_sample(8'(n * 5), 8'(100 - n));
        valid_i = 1'b0;
        wait_drain();
        checks++;
        if (sbq.size() != 0) begin errors++; $display("[TB] FAIL rst_mid_drain: got %0d pending required 0", sbq.size()); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        stalls = 0;
        mcnt   = 0;
        test_reset();
        test_ramp();
        test_continuous();
        test_backpressure();
        test_random();
        test_ce();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_input_reorder.md
# fft_input_reorder

Input-side companion of the FFT output reorder stage. Accepts complex samples in natural order, one per cycle, into a ping-pong frame buffer. Emits each completed frame to the radix-2 FFT core as complex pairs in bit-reversed order, two samples per cycle. Sits between the sample source (ADC/decimator) and the FFT butterfly pipeline.

## Interface
- `width`, default 8: bits per real/imag component (two's complement, passed through unmodified)
- `points`, default 64: frame length N, a power of two, 8 ≤ N ≤ 1024
- `logpoints`, default 6: log2(points)
- `CLK`, input, 1: sole clock, rising edge
- `RST`, input, 1: reset, asynchronous, active-low
- `ce`, input, 1: global clock enable; when low, all state, counters, RAM reads and outputs hold
- `valid_i`, input, 1: input sample valid
- `ready_o`, output, 1: input can accept a sample
- `dr`, `di`, input, width each: input sample real/imag
- `valid_o`, output, 1: output pair valid
- `ready_i`, input, 1: FFT core accepts the output pair
- `sof_o`, output, 1: high with the first pair (k=0) of each frame
- `ar`, `ai`, `br`, `bi`, output, width each: pair k, where a = x[rev(2k)] and b = x[rev(2k+1)]; rev is bit reversal over logpoints bits

## Operation
- Storage: 2 frame buffers (sel 0/1). Each buffer has a lower bank holding n < N/2 and an upper bank holding n ≥ N/2, both at address n mod N/2.
  - Because rev(2k+1) = rev(2k) + N/2 and rev(2k) = rev_{logpoints-1}(k), both banks are read at the same address rev_{logpoints-1}(k).
- Flags: `full[1:0]`, `wr_sel`, `wcnt` (logpoints bits); `rd_sel`, `rcnt` (logpoints-1 bits). All reset to 0.
- Write side:
  - `ready_o = !full[wr_sel]`, which is combinational.
  - A write is accepted when `ce && valid_i && ready_o`. It writes to bank `wcnt[msb]` of `wr_sel` at `wcnt[logpoints-2:0]`, then `wcnt++`.
  - On the write with wcnt = N-1: set `full[wr_sel]`, toggle `wr_sel`, and wcnt wraps to 0.
- Read FSM, states IDLE and DRAIN. `adv = ce && (!valid_o || ready_i)`.
  - IDLE → DRAIN when `ce && full[rd_sel]`, with rcnt = 0.
  - In DRAIN, each adv cycle issues a read at address rev(rcnt) in both banks of rd_sel, then `rcnt++`.
  - On the adv cycle with rcnt = N/2-1: clear `full[rd_sel]` and toggle `rd_sel`. If the other buffer is full in that cycle, stay in DRAIN with rcnt = 0 (back-to-back frames); otherwise go to IDLE.
- Output stage:
  - The RAM output register is the output register, with read enable = adv.
  - `valid_o` and `sof_o` load on adv: valid_o gets "a read was issued this cycle", and sof_o gets "read issued with rcnt = 0".
  - When valid_o is low, ar/ai/br/bi are forced to 0.
- Simultaneous events:
  - A set of `full[wr_sel]` and a clear of `full[rd_sel]` in the same cycle on different bits both take effect.
  - The same bit cannot be both set and cleared in one cycle, because a buffer is never written while full.
- Reset mid-operation clears flags, counters, FSM, valid_o and sof_o. Buffer contents are abandoned; a partial frame is lost.

## Timing
- Reset values: ready_o=1, valid_o=0, sof_o=0, ar/ai/br/bi=0.
- Latency: let edge E0 accept the last sample of a frame (with the read side idle, ce high and ready_i high throughout).
  - E1: FSM enters DRAIN.
  - E2: read of pair 0 issued.
  - After E3: valid_o=1 and sof_o=1, so the first pair is presented 3 cycles after the last input edge.
- Throughput: output is N/2 consecutive cycles per frame while ready_i is high. The drain (N/2 cycles) is shorter than the fill (N cycles), so with ready_i held high ready_o never falls under continuous input.
- Backpressure: with ready_i low, valid_o and data hold stable and no read advances.
- ce low freezes everything, including the handshake: no accept and no advance.

## Structure
- Shared package `fft_pkg` holds:
  - the IDLE/DRAIN state encoding;
  - a `bitrev` function parameterised by bit count;
  - the width/points/logpoints defaults, shared with the FFT core and the output reorder stage.
- One sub-module, `fft_input_bank`: one frame buffer built from two of the codebase's existing `dpram` instances (lower/upper half).
  - Port A: write. Port B: synchronous read with enable.
  - Instantiated twice.

## Test plan
- Ramp: dr = n, di = -n for n = 0..63, ready_i=1 → 32 pairs. Pair 0 = (0, 32) with sof_o=1, pair 1 = (16, 48), pair 2 = (8, 40), pair 31 = (31, 63); ai/bi are the negations. First valid_o comes 3 cycles after the last accept.
- Four continuous frames with valid_i held high → ready_o never low, and each frame's 32 pairs are correct with no gaps between frames.
- ready_i low for the whole of frames 2 and 3 → after both buffers fill, ready_o=0 while valid_o holds pair 0 of frame 1 stable. Releasing ready_i drains in order and ready_o returns after frame 1 completes.
- Random ready_i and valid_i toggling over 8 frames → scoreboard against a bit-reversal model, with no lost or duplicated pairs.
- ce low for 5 cycles mid-fill and mid-drain → outputs, ready_o and counters are frozen, and results are identical to the ce-high run.
- RST asserted after 40 samples of frame 1 → immediately valid_o=0, ready_o=1 and outputs 0. The next 64 samples form a correct frame 0.
